direction_button_ctrl: RTL
==========================

# direction_button_ctrl

Conditions the raw direction push-button and produces the DIRECTION level consumed by the 4-bit LED counter. Raw input is synchronised, debounced by a four-state FSM, and each qualified press toggles DIRECTION. The block also emits one-cycle press and long-press pulses for other consumers.

## Interface
- DEBOUNCE_CYCLES, 270000: consecutive stable samples needed to accept a press or release (20 ms at 13.5 MHz); legal range 1..2^24-1.
- LONG_CYCLES, 13500000: held cycles after press acceptance before LONG_PULSE fires (1 s at 13.5 MHz); legal range 1..2^24-1.
- ACTIVE_LOW, 1: 1 = BUTTON_IN low means pressed; 0 = high means pressed.
- CLOCK  input  1  system clock; single clock domain.
- RESET_N  input  1  reset; asynchronous, active-low.
- BUTTON_IN  input  1  raw, asynchronous, bouncing button pin.
- DIRECTION  output  1  registered count direction; 1 = up, 0 = down.
- PRESS_PULSE  output  1  one-cycle pulse on each accepted press.
- LONG_PULSE  output  1  one-cycle pulse, at most once per press, after LONG_CYCLES of holding.
- BUTTON_STATE  output  1  debounced level; 1 = pressed (states HELD and DB_RELEASE).

## Operation
- Synchroniser: two flops normalise polarity to pressed = 1. Both reset to 0 (released).
- FSM states:
  - IDLE: sync = 1 -> DB_PRESS, db_cnt = 0.
  - DB_PRESS: sync = 0 -> IDLE (glitch rejected, no outputs). Otherwise, db_cnt == DEBOUNCE_CYCLES-1 -> HELD, PRESS_PULSE = 1, DIRECTION toggles, hold_cnt = 0, long_done = 0. Otherwise db_cnt++.
  - HELD: sync = 0 -> DB_RELEASE, db_cnt = 0. Otherwise, hold_cnt == LONG_CYCLES-1 and long_done = 0 -> LONG_PULSE = 1, long_done = 1. Otherwise hold_cnt++ while long_done = 0 (frozen after firing, no wrap).
  - DB_RELEASE: sync = 1 -> HELD, with hold_cnt and long_done unchanged and no new PRESS_PULSE (release bounce is not a press). Otherwise, db_cnt == DEBOUNCE_CYCLES-1 -> IDLE. Otherwise db_cnt++.
- Counters: db_cnt and hold_cnt are 24-bit unsigned. Comparisons are exact equality and no counter ever wraps.
- Each accepted press toggles DIRECTION exactly once, however long the button is held.
- Reset values: FSM = IDLE, counters = 0, long_done = 0, DIRECTION = 1, PRESS_PULSE = 0, LONG_PULSE = 0, BUTTON_STATE = 0.
- Reset asserted mid-press clears everything asynchronously. A button still held at deassertion must be re-debounced from IDLE and produces a toggle only after a full debounce.

## Timing
- All outputs are registered. PRESS_PULSE and LONG_PULSE are high for exactly one CLOCK cycle.
- Let edge k be the first edge that samples pressed into sync flop 1.
  - Edge k+2: DB_PRESS entered.
  - Edge k+DEBOUNCE_CYCLES+2: PRESS_PULSE high, DIRECTION toggled, BUTTON_STATE = 1 (same edge).
  - Edge H+LONG_CYCLES: LONG_PULSE high, where H is the HELD-entry edge.
- Release with no bounce: BUTTON_STATE falls at edge r+DEBOUNCE_CYCLES+2, where r is the first edge sampling released.
- A bounce of fewer than DEBOUNCE_CYCLES samples during DB_PRESS produces no output change and restarts the debounce from IDLE.
- Downstream counter samples DIRECTION only on its own tick; no handshake is required.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
- Reset: hold RESET_N=0 with BUTTON_IN toggling -> DIRECTION=1, all other outputs 0. Release reset with BUTTON_IN=1 -> no output change for 50 cycles.
- Clean press: BUTTON_IN 1->0 sampled at edge k, held -> PRESS_PULSE single cycle at k+6, DIRECTION 1->0 at k+6, BUTTON_STATE=1 at k+6.
- Glitch rejection: BUTTON_IN low for 3 cycles then high -> no PRESS_PULSE, DIRECTION stays 1, FSM returns to IDLE.
- Long press: hold low 40 cycles after acceptance -> exactly one LONG_PULSE at HELD entry+20, DIRECTION toggled once only.
- Release bounce: after acceptance, pulse BUTTON_IN high 2 cycles, low 2, high stable -> no second PRESS_PULSE; BUTTON_STATE falls 6 edges after the final rising sample.
- Reset mid-hold: assert RESET_N=0 during HELD, deassert with button still low -> DIRECTION=1 immediately; new toggle to 0 exactly 6 edges after the first post-reset sampling edge.

Source files
------------

// File: rtl/direction_button_ctrl.sv
// Purpose: synchronise and debounce the direction push-button; each accepted press toggles DIRECTION.
// Latency: press accepted DEBOUNCE_CYCLES+2 edges after the first pressed sample; all outputs registered.
// Backpressure: none; outputs are levels or single-cycle pulses that consumers sample freely.
`timescale 1ns/1ps
module direction_button_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned LONG_CYCLES     = 13500000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic BUTTON_IN,
  output logic DIRECTION,
  output logic PRESS_PULSE,
  output logic LONG_PULSE,
  output logic BUTTON_STATE
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  // Terminal counts; equality compares against these, so counters never wrap.
  localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] LONG_LAST = 24'(LONG_CYCLES - 1);

  // Polarity normalised so that 1 always means pressed.
  logic raw_pressed;
  logic sync1;
  logic sync2;

  state_t      state;
  state_t      state_nxt;
  logic [23:0] db_cnt;
  logic [23:0] db_cnt_nxt;
  logic [23:0] hold_cnt;
  logic [23:0] hold_cnt_nxt;
  logic        long_done;
  logic        long_done_nxt;
  logic        direction_nxt;
  logic        press_nxt;
  logic        long_nxt;
  logic        button_state_nxt;

  assign raw_pressed = ACTIVE_LOW ? ~BUTTON_IN : BUTTON_IN;

  // Two-flop synchroniser for the asynchronous pin; resets to released.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_pressed;
      sync2 <= sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, counter and output decode for the debounce FSM.
  always_comb begin
    state_nxt     = state;
    db_cnt_nxt    = db_cnt;
    hold_cnt_nxt  = hold_cnt;
    long_done_nxt = long_done;
    direction_nxt = DIRECTION;
    press_nxt     = 1'b0;
    long_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (sync2) begin
          state_nxt  = DB_PRESS;
          db_cnt_nxt = 24'd0;
        end
      end

      DB_PRESS: begin
        if (!sync2) begin
          // Too short to be a press: drop back without touching any output.
          state_nxt = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nxt     = HELD;
          press_nxt     = 1'b1;
          direction_nxt = ~DIRECTION;
          hold_cnt_nxt  = 24'd0;
          long_done_nxt = 1'b0;
        end else begin
          db_cnt_nxt = db_cnt + 24'd1;
        end
      end

      HELD: begin
        if (!sync2) begin
          state_nxt  = DB_RELEASE;
          db_cnt_nxt = 24'd0;
        end else if (!long_done) begin
          if (hold_cnt == LONG_LAST) begin
            long_nxt      = 1'b1;
            long_done_nxt = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt + 24'd1;
          end
        end
      end

      DB_RELEASE: begin
        if (sync2) begin
          // Release bounce: resume the hold with its progress intact, no new press.
          state_nxt = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = IDLE;
        end else begin
          db_cnt_nxt = db_cnt + 24'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    button_state_nxt = (state_nxt == HELD) || (state_nxt == DB_RELEASE);
  end

  // Counters, long-press latch and registered outputs.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      db_cnt       <= 24'd0;
      hold_cnt     <= 24'd0;
      long_done    <= 1'b0;
      DIRECTION    <= 1'b1;
      PRESS_PULSE  <= 1'b0;
      LONG_PULSE   <= 1'b0;
      BUTTON_STATE <= 1'b0;
    end else begin
      db_cnt       <= db_cnt_nxt;
      hold_cnt     <= hold_cnt_nxt;
      long_done    <= long_done_nxt;
      DIRECTION    <= direction_nxt;
      PRESS_PULSE  <= press_nxt;
      LONG_PULSE   <= long_nxt;
      BUTTON_STATE <= button_state_nxt;
    end
  end

endmodule
